// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared ALU widths, opcodes, flag indices and arbiter types
package alu_share_arbiter_pkg;

    localparam int DW  = 16;
    localparam int OPW = 3;
    localparam int FW  = 3;

    localparam int FLG_N = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRL    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADDSB = 3'd7
    } alu_op_e;

    // EMPTY: no response held; FULL: rsp_* carries a valid response
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    typedef struct packed {
        logic [DW-1:0]  in1;
        logic [DW-1:0]  in2;
        logic [OPW-1:0] op;
        logic           flag_we;
    } alu_req_t;

    // selects the requester payload that drives the ALU this cycle
    function automatic alu_req_t pick_req(input logic sel, input alu_req_t r0, input alu_req_t r1);
        return sel ? r1 : r0;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU and response signals of the shared ALU arbiter
interface alu_share_arbiter_if;
    import alu_share_arbiter_pkg::*;

    logic           req0_valid;
    logic           req0_ready;
    logic [DW-1:0]  req0_in1;
    logic [DW-1:0]  req0_in2;
    logic [OPW-1:0] req0_op;
    logic           req0_flag_we;

    logic           req1_valid;
    logic           req1_ready;
    logic [DW-1:0]  req1_in1;
    logic [DW-1:0]  req1_in2;
    logic [OPW-1:0] req1_op;
    logic           req1_flag_we;

    logic [DW-1:0]  alu_in1;
    logic [DW-1:0]  alu_in2;
    logic [OPW-1:0] alu_op;
    logic [FW-1:0]  alu_flag_in;
    logic [DW-1:0]  alu_out;
    logic [FW-1:0]  alu_flag;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [DW-1:0]  rsp_data;
    logic [FW-1:0]  rsp_flag;
    logic [FW-1:0]  flag_q;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op, req0_flag_we,
        input  req1_valid, req1_in1, req1_in2, req1_op, req1_flag_we,
        output req0_ready, req1_ready,
        output alu_in1, alu_in2, alu_op, alu_flag_in,
        input  alu_out, alu_flag,
        output rsp_valid, rsp_id, rsp_data, rsp_flag, flag_q,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op, req0_flag_we,
        output req1_valid, req1_in1, req1_in2, req1_op, req1_flag_we,
        input  req0_ready, req1_ready,
        input  alu_in1, alu_in2, alu_op, alu_flag_in,
        output alu_out, alu_flag,
        input  rsp_valid, rsp_id, rsp_data, rsp_flag, flag_q,
        output rsp_ready
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant memory
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    // a lone requester wins; on contention the port not served last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // remember the winner only when its op is actually issued; reset leaves port 0 preferred
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between two requesters, registers result and flags
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    rsp_state_e     state_q;
    rsp_state_e     state_d;
    logic [1:0]     gnt;
    logic           rsp_valid;
    logic           can_issue;
    logic           issue;
    alu_req_t       r0;
    alu_req_t       r1;
    alu_req_t       sel_req;
    logic           rsp_id_q;
    logic [DW-1:0]  rsp_data_q;
    logic [FW-1:0]  rsp_flag_q;
    logic [FW-1:0]  flag_q;

    assign r0 = {bus.req0_in1, bus.req0_in2, bus.req0_op, bus.req0_flag_we};
    assign r1 = {bus.req1_in1, bus.req1_in2, bus.req1_op, bus.req1_flag_we};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.req1_valid, bus.req0_valid}),
        .advance (issue),
        .gnt     (gnt)
    );

    // with no grant gnt[1]=0, so port 0 payload sits on the ALU as a don't-care
    assign sel_req         = pick_req(gnt[1], r0, r1);
    assign bus.alu_in1     = sel_req.in1;
    assign bus.alu_in2     = sel_req.in2;
    assign bus.alu_op      = sel_req.op;
    assign bus.alu_flag_in = flag_q;

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flag  = rsp_flag_q;
    assign bus.flag_q    = flag_q;

    // response-slot state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // slot fills on issue and empties when drained without a refill
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (issue)                   state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !issue) state_d = ST_EMPTY;
            default:                               state_d = ST_EMPTY;
        endcase
    end

    // slot can accept when empty or being drained this cycle; readies never look at payload
    always_comb begin
        rsp_valid      = (state_q == ST_FULL);
        can_issue      = !rsp_valid || bus.rsp_ready;
        issue          = can_issue && (gnt != 2'b00);
        bus.req0_ready = can_issue && gnt[0];
        bus.req1_ready = can_issue && gnt[1];
    end

    // capture ALU result and flags at issue; commit architectural flags only when asked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_flag_q <= '0;
            flag_q     <= '0;
        end else if (issue) begin
            rsp_id_q   <= gnt[1];
            rsp_data_q <= bus.alu_out;
            rsp_flag_q <= bus.alu_flag;
            if (sel_req.flag_we) begin
                flag_q <= bus.alu_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural ALU: returns {Z,V,N,result}; Z is sticky from the incoming flags
    function automatic logic [18:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op, input logic [2:0] fin);
        logic [15:0] r;
        logic        v;
        logic [3:0]  sh;
        v  = 1'b0;
        sh = b[3:0];
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a ^ b;
            3'd3: r = {15'd0, ^a};
            3'd4: r = a << sh;
            3'd5: r = a >> sh;
            3'd6: r = (a >> sh) | (a << (5'd16 - {1'b0, sh}));
            default: begin r[15:8] = a[15:8] + b[15:8]; r[7:0] = a[7:0] + b[7:0]; end
        endcase
        return {(r == 16'd0) | fin[2], v, r[15], r};
    endfunction

    logic [18:0] alu_res;
    assign alu_res      = alu_ref(bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_flag_in);
    assign bus.alu_out  = alu_res[15:0];
    assign bus.alu_flag = alu_res[18:16];

    task automatic set_req(input int p, input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic we);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_op = op; bus.req0_flag_we = we;
        end else begin
            bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_op = op; bus.req1_flag_we = we;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%h exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%h exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0000", bus.rsp_data); end
        checks++; if (bus.rsp_flag !== 3'b000) begin errors++; $display("FAIL reset_rsp_flag got=%b exp=000", bus.rsp_flag); end
        checks++; if (bus.flag_q !== 3'b000) begin errors++; $display("FAIL reset_flag_q got=%b exp=000", bus.flag_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 1'b1, 16'h0003, 16'h0004, OP_ADD, 1'b1);
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got=%b exp=0", bus.req1_ready); end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got=%b exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 16'h0007) begin errors++; $display("FAIL single_rsp_data got=%h exp=0007", bus.rsp_data); end
        checks++; if (bus.flag_q !== 3'b000) begin errors++; $display("FAIL single_flag_q got=%b exp=000", bus.flag_q); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d;
        logic        exp_g1;
        do_reset();
        set_req(0, 1'b1, 16'h00FF, 16'h0F0F, OP_XOR, 1'b0);
        set_req(1, 1'b1, 16'h1000, 16'h0234, OP_ADD, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_g1 = (i % 2) == 1;
            exp_d  = exp_g1 ? 16'h1234 : 16'h0FF0;
            @(negedge clk);
            checks++; if (bus.req0_ready !== !exp_g1) begin errors++; $display("FAIL rr_req0_ready[%0d] got=%b exp=%b", i, bus.req0_ready, !exp_g1); end
            checks++; if (bus.req1_ready !== exp_g1) begin errors++; $display("FAIL rr_req1_ready[%0d] got=%b exp=%b", i, bus.req1_ready, exp_g1); end
            @(posedge clk);
            #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== exp_g1) begin errors++; $display("FAIL rr_rsp_id[%0d] got=%b exp=%b", i, bus.rsp_id, exp_g1); end
            checks++; if (bus.rsp_data !== exp_d) begin errors++; $display("FAIL rr_rsp_data[%0d] got=%h exp=%h", i, bus.rsp_data, exp_d); end
        end
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
    endtask

    task automatic test_sub_noflag();
        do_reset();
        set_req(1, 1'b1, 16'h0001, 16'h0002, OP_SUB, 1'b0);
        @(negedge clk);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL sub_req1_ready got=%b exp=1", bus.req1_ready); end
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL sub_rsp_id got=%b exp=1", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 16'hFFFF) begin errors++; $display("FAIL sub_rsp_data got=%h exp=FFFF", bus.rsp_data); end
        checks++; if (bus.rsp_flag !== 3'b001) begin errors++; $display("FAIL sub_rsp_flag got=%b exp=001", bus.rsp_flag); end
        checks++; if (bus.flag_q !== 3'b000) begin errors++; $display("FAIL sub_flag_q got=%b exp=000", bus.flag_q); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 1'b1, 16'h0001, 16'h0001, OP_ADD, 1'b0);
        set_req(1, 1'b1, 16'h0005, 16'h0005, OP_ADD, 1'b0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready[%0d] got=%b exp=0", i, bus.req0_ready); end
            checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_ready[%0d] got=%b exp=0", i, bus.req1_ready); end
            @(posedge clk);
            #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL bp_rsp_id[%0d] got=%b exp=0", i, bus.rsp_id); end
            checks++; if (bus.rsp_data !== 16'h0002) begin errors++; $display("FAIL bp_rsp_data[%0d] got=%h exp=0002", i, bus.rsp_data); end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_req1_ready got=%b exp=1", bus.req1_ready); end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_refill_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_refill_id got=%b exp=1", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 16'h000A) begin errors++; $display("FAIL bp_refill_data got=%h exp=000A", bus.rsp_data); end
    endtask

    task automatic test_flag_chain();
        do_reset();
        set_req(0, 1'b1, 16'h7FFF, 16'h0001, OP_ADD, 1'b1);
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_data !== 16'h8000) begin errors++; $display("FAIL flag_ovf_data got=%h exp=8000", bus.rsp_data); end
        checks++; if (bus.flag_q !== 3'b011) begin errors++; $display("FAIL flag_ovf_flag_q got=%b exp=011", bus.flag_q); end
        set_req(0, 1'b1, 16'h0000, 16'h0000, OP_XOR, 1'b0);
        @(negedge clk);
        checks++; if (bus.alu_flag_in !== 3'b011) begin errors++; $display("FAIL flag_chain_flag_in got=%b exp=011", bus.alu_flag_in); end
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL flag_chain_ready got=%b exp=1", bus.req0_ready); end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        checks++; if (bus.rsp_flag !== 3'b100) begin errors++; $display("FAIL flag_chain_rsp_flag got=%b exp=100", bus.rsp_flag); end
        checks++; if (bus.flag_q !== 3'b011) begin errors++; $display("FAIL flag_chain_flag_q got=%b exp=011", bus.flag_q); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 1'b1, 16'h0000, 16'h0001, OP_SUB, 1'b1);
        set_req(1, 1'b1, 16'h0003, 16'h0004, OP_ADD, 1'b0);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.flag_q !== 3'b001) begin errors++; $display("FAIL rmid_pre_flag_q got=%b exp=001", bus.flag_q); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.flag_q !== 3'b000) begin errors++; $display("FAIL rmid_flag_q got=%b exp=000", bus.flag_q); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_req0_ready got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_req1_ready got=%b exp=0", bus.req1_ready); end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL rmid_rsp_id got=%b exp=0", bus.rsp_id); end
    endtask

    task automatic test_random();
        logic        pv[2];
        logic [15:0] pa[2];
        logic [15:0] pb[2];
        logic [2:0]  pop[2];
        logic        pwe[2];
        bit          hold[2];
        logic        m_valid;
        logic        m_id;
        logic [15:0] m_data;
        logic [2:0]  m_flag;
        logic [2:0]  m_flagq;
        logic [18:0] res;
        int          m_last;
        int          g;
        bit          can;
        do_reset();
        m_valid = 1'b0; m_id = 1'b0; m_data = 16'h0; m_flag = 3'b0; m_flagq = 3'b0; m_last = 1;
        hold[0] = 1'b0; hold[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hold[p]) begin
                    pv[p]  = ($urandom % 4) != 0;
                    pa[p]  = 16'($urandom);
                    pb[p]  = 16'($urandom);
                    pop[p] = 3'($urandom);
                    pwe[p] = 1'($urandom);
                    set_req(p, pv[p], pa[p], pb[p], pop[p], pwe[p]);
                end
            end
            bus.rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            can = !m_valid || bus.rsp_ready;
            g = -1;
            if (can) begin
                if (pv[0] && pv[1]) g = (m_last == 0) ? 1 : 0;
                else if (pv[0])     g = 0;
                else if (pv[1])     g = 1;
            end
            checks++; if (bus.req0_ready !== (g == 0)) begin errors++; $display("FAIL rnd_req0_ready[%0d] got=%b exp=%b", cyc, bus.req0_ready, (g == 0)); end
            checks++; if (bus.req1_ready !== (g == 1)) begin errors++; $display("FAIL rnd_req1_ready[%0d] got=%b exp=%b", cyc, bus.req1_ready, (g == 1)); end
            checks++; if (bus.alu_flag_in !== m_flagq) begin errors++; $display("FAIL rnd_alu_flag_in[%0d] got=%b exp=%b", cyc, bus.alu_flag_in, m_flagq); end
            if (g >= 0) begin
                checks++;
                if (bus.alu_in1 !== pa[g] || bus.alu_in2 !== pb[g] || bus.alu_op !== pop[g]) begin
                    errors++;
                    $display("FAIL rnd_alu_operands[%0d] got=%h/%h/%0d exp=%h/%h/%0d", cyc, bus.alu_in1, bus.alu_in2, bus.alu_op, pa[g], pb[g], pop[g]);
                end
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                res     = alu_ref(pa[g], pb[g], pop[g], m_flagq);
                m_data  = res[15:0];
                m_flag  = res[18:16];
                m_id    = g[0];
                m_valid = 1'b1;
                if (pwe[g]) m_flagq = m_flag;
                m_last  = g;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            checks++; if (bus.rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_rsp_valid[%0d] got=%b exp=%b", cyc, bus.rsp_valid, m_valid); end
            checks++; if (bus.flag_q !== m_flagq) begin errors++; $display("FAIL rnd_flag_q[%0d] got=%b exp=%b", cyc, bus.flag_q, m_flagq); end
            checks++;
            if (bus.rsp_id !== m_id || bus.rsp_data !== m_data || bus.rsp_flag !== m_flag) begin
                errors++;
                $display("FAIL rnd_rsp_payload[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, bus.rsp_id, bus.rsp_data, bus.rsp_flag, m_id, m_data, m_flag);
            end
            for (int p = 0; p < 2; p++) begin
                hold[p] = pv[p] && (g != p);
            end
        end
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
    endtask

    initial begin
        set_req(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_sub_noflag();
        test_backpressure();
        test_flag_chain();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
